// File: rtl/param_shift_register.sv
// Parameterised shift/rotate/load register driven by a two-state FSM.
// An accepted operation runs repeat_cnt steps of the latched mode and
// shamt, one step per clock, then pulses done for a single cycle.
module param_shift_register #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       mode,
  input  logic [SH_W-1:0]  shamt,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [SH_W-1:0]  shamt_q, shamt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             msb_q, lsb_q, done_q, done_d;

  logic [SH_W-1:0]  rot_k;
  logic [WIDTH-1:0] step_res;

  // Rotate amount reduced modulo WIDTH; shamt can exceed WIDTH-1 only
  // when WIDTH is not a power of two, and never reaches 2*WIDTH.
  always_comb begin
    if (int'(shamt_q) >= WIDTH) rot_k = SH_W'(int'(shamt_q) - WIDTH);
    else                        rot_k = shamt_q;
  end

  // Result of one step of the latched mode applied to the current contents.
  // Shifts by WIDTH or more naturally yield an all-fill word, since the
  // data term shifts to zero and the fill mask covers every bit.
  always_comb begin
    step_res = data_q;
    unique case (mode_q)
      3'b000: step_res = data_q;
      3'b001: step_res = (data_q >> shamt_q) | (msb_in ? ~(ONES >> shamt_q) : '0);
      3'b010: step_res = (data_q >> rot_k) | (data_q << (WIDTH - int'(rot_k)));
      3'b011: step_res = (data_q >> shamt_q)
                       | (data_q[WIDTH-1] ? ~(ONES >> shamt_q) : '0);
      3'b100: step_res = (data_q << shamt_q) | (lsb_in ? ~(ONES << shamt_q) : '0);
      3'b101: step_res = (data_q << shamt_q) | (data_q[0] ? ~(ONES << shamt_q) : '0);
      3'b110: step_res = (data_q << rot_k) | (data_q >> (WIDTH - int'(rot_k)));
      3'b111: step_res = data_in;
      default: step_res = data_q;
    endcase
  end

  // Next-state and operation bookkeeping for the IDLE/RUN controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (repeat_cnt != '0) begin
            mode_d  = mode;
            shamt_d = shamt;
            cnt_d   = repeat_cnt;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        data_d = step_res;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; the edge-bit
  // copies track the pre-edge contents on every non-reset edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      msb_q   <= data_q[WIDTH-1];
      lsb_q   <= data_q[0];
      done_q  <= done_d;
    end
  end

  assign op_ready = (state_q == IDLE);
  assign data_out = data_q;
  assign msb_out  = msb_q;
  assign lsb_out  = lsb_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register (WIDTH=8): directed scenarios followed by
// randomized traffic, compared every cycle against a bit-level reference.
module tb_param_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   mode;
  logic [2:0]   shamt;
  logic [7:0]   repeat_cnt;
  logic         msb_in, lsb_in;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         msb_out, lsb_out, done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit           m_busy;
  int           m_rem;
  int           m_mode, m_k;
  logic [W-1:0] m_data;
  logic         m_msb, m_lsb, m_done;

  param_shift_register #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .mode(mode), .shamt(shamt), .repeat_cnt(repeat_cnt),
    .msb_in(msb_in), .lsb_in(lsb_in), .data_in(data_in),
    .data_out(data_out), .msb_out(msb_out), .lsb_out(lsb_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One step computed bit by bit from the operation definitions.
  function automatic logic [W-1:0] model_step(input int md, input int k, input logic [W-1:0] d,
                                               input logic mi, input logic li,
                                               input logic [W-1:0] din);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (md)
        1: r[i] = (i + k < W) ? d[i + k] : mi;
        2: r[i] = d[(i + k) % W];
        3: r[i] = (i + k < W) ? d[i + k] : d[W-1];
        4: r[i] = (i >= k) ? d[i - k] : li;
        5: r[i] = (i >= k) ? d[i - k] : d[0];
        6: r[i] = d[(i - k + W) % W];
        7: r[i] = din[i];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Advance one clock: model consumes the stable inputs, then outputs are compared.
  task automatic tick();
    bit           n_busy = m_busy;
    int           n_rem  = m_rem;
    int           n_mode = m_mode, n_k = m_k;
    logic [W-1:0] n_data = m_data;
    logic         n_msb, n_lsb, n_done;
    if (rst) begin
      n_busy = 0; n_rem = 0; n_data = '0; n_msb = 0; n_lsb = 0; n_done = 0;
    end else begin
      n_msb  = m_data[W-1];
      n_lsb  = m_data[0];
      n_done = 0;
      if (!m_busy) begin
        if (op_valid) begin
          if (repeat_cnt > 0) begin
            n_busy = 1; n_rem = int'(repeat_cnt); n_mode = int'(mode); n_k = int'(shamt);
          end else begin
            n_done = 1;
          end
        end
      end else begin
        n_data = model_step(m_mode, m_k, m_data, msb_in, lsb_in, data_in);
        n_rem  = m_rem - 1;
        if (n_rem == 0) begin
          n_busy = 0;
          n_done = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    m_busy = n_busy; m_rem = n_rem; m_mode = n_mode; m_k = n_k;
    m_data = n_data; m_msb = n_msb; m_lsb = n_lsb; m_done = n_done;
    check("data_out", 64'(data_out), 64'(m_data));
    check("msb_out",  64'(msb_out),  64'(m_msb));
    check("lsb_out",  64'(lsb_out),  64'(m_lsb));
    check("done",     64'(done),     64'(m_done));
    check("op_ready", 64'(op_ready), 64'(!m_busy));
  endtask

  task automatic set_op(input logic v, input logic [2:0] md, input logic [2:0] k,
                        input logic [7:0] rep);
    op_valid = v; mode = md; shamt = k; repeat_cnt = rep;
  endtask

  // Load value and finish the load operation (accept + one step).
  task automatic load(input logic [W-1:0] val);
    data_in = val;
    set_op(1'b1, 3'b111, 3'd0, 8'd1);
    tick();
    op_valid = 1'b0;
    tick();
  endtask

  initial begin
    m_busy = 0; m_rem = 0; m_mode = 0; m_k = 0;
    m_data = '0; m_msb = 0; m_lsb = 0; m_done = 0;
    rst = 1'b1; msb_in = 1'b0; lsb_in = 1'b0; data_in = '0;
    set_op(1'b0, 3'b000, 3'd0, 8'd0);
    @(negedge clk);
    tick();
    check("reset_data", 64'(data_out), 64'h0);
    check("reset_ready", 64'(op_ready), 64'h1);
    rst = 1'b0;
    tick();

    // Parallel load of 0xA5.
    load(8'hA5);
    check("load_value", 64'(data_out), 64'hA5);
    check("load_done", 64'(done), 64'h1);
    tick();

    // Rotate right by one, three times.
    set_op(1'b1, 3'b010, 3'd1, 8'd3);
    tick();
    op_valid = 1'b0;
    tick(); check("rotr_1", 64'(data_out), 64'hD2);
    tick(); check("rotr_2", 64'(data_out), 64'h69);
    tick(); check("rotr_3", 64'(data_out), 64'hB4);
    check("rotr_done", 64'(done), 64'h1);

    // Arithmetic right by two, twice, from 0x90.
    load(8'h90);
    set_op(1'b1, 3'b011, 3'd2, 8'd2);
    tick();
    op_valid = 1'b0;
    tick(); check("asr_1", 64'(data_out), 64'hE4);
    tick(); check("asr_2", 64'(data_out), 64'hF9);

    // Left shift by three with serial fill of ones, from 0x01.
    load(8'h01);
    lsb_in = 1'b1;
    set_op(1'b1, 3'b100, 3'd3, 8'd1);
    tick();
    op_valid = 1'b0;
    tick(); check("shl_fill", 64'(data_out), 64'h0F);
    lsb_in = 1'b0;
    tick(); check("lsb_prev", 64'(lsb_out), 64'h1);

    // Zero repeat count: no data change, done right after the accept edge.
    set_op(1'b1, 3'b111, 3'd0, 8'd0);
    data_in = 8'h33;
    tick(); check("rep0_done", 64'(done), 64'h1);
    check("rep0_data", 64'(data_out), 64'h0F);

    // op_valid held through RUN is ignored; next op accepted in the done cycle.
    set_op(1'b1, 3'b110, 3'd1, 8'd3);
    tick();
    set_op(1'b1, 3'b111, 3'd0, 8'd2);
    tick(); tick(); tick();
    check("held_done", 64'(done), 64'h1);
    check("held_data", 64'(data_out), 64'h78);
    tick();
    check("b2b_busy", 64'(op_ready), 64'h0);
    op_valid = 1'b0;
    tick(); tick();

    // Reset on the second step of a five-step operation.
    set_op(1'b1, 3'b110, 3'd2, 8'd5);
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_data", 64'(data_out), 64'h0);
    rst = 1'b0;
    tick();
    check("abort_nodone", 64'(done), 64'h0);
    check("abort_ready", 64'(op_ready), 64'h1);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      op_valid   = 1'($urandom);
      mode       = 3'($urandom);
      shamt      = 3'($urandom);
      repeat_cnt = 8'($urandom_range(0, 4));
      msb_in     = 1'($urandom);
      lsb_in     = 1'($urandom);
      data_in    = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 SHALL provide parameter CNT_W, default 8, width of the repeat count.
REQ-003 SHALL derive SH_W = clog2(WIDTH) internally; it is not overridable.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 op_valid  input  1  operation request.
REQ-008 op_ready  output  1  block can accept an operation; combinational, high exactly when in IDLE.
REQ-009 mode  input  3  operation code, sampled at accept.
REQ-010 shamt  input  SH_W  bits moved per step, sampled at accept.
REQ-011 repeat_cnt  input  CNT_W  number of steps, sampled at accept.
REQ-012 msb_in, lsb_in  input  1 each  serial fill bits, sampled live on every step.
REQ-013 data_in  input  WIDTH  parallel load value, sampled live on every load step.
REQ-014 data_out  output  WIDTH  register contents (registered).
REQ-015 msb_out, lsb_out  output  1 each  registered copies of data_out[WIDTH-1] and data_out[0] as they stood before the most recent clock edge.
REQ-016 done  output  1  one-cycle pulse marking operation completion (registered).

Function
REQ-017 SHALL implement a two-state FSM: IDLE and RUN.
REQ-018 SHALL accept an operation at an edge where op_valid=1 and op_ready=1; in RUN, op_valid SHALL be ignored.
REQ-019 On accept with repeat_cnt>0, SHALL latch mode, shamt and repeat_cnt, enter RUN, and leave data_out unchanged.
REQ-020 On accept with repeat_cnt=0, SHALL stay in IDLE, leave data_out unchanged and assert done the following cycle.
REQ-021 Each RUN edge SHALL perform exactly one step, per REQ-022 to REQ-029, and decrement the remaining count.
REQ-022 mode 000: hold; data_out unchanged (the step still counts).
REQ-023 mode 001: logical right shift by k=shamt; vacated top k bits filled with msb_in.
REQ-024 mode 010: rotate right by k.
REQ-025 mode 011: arithmetic right shift by k; vacated bits take the old data_out[WIDTH-1].
REQ-026 mode 100: left shift by k; vacated low k bits filled with lsb_in.
REQ-027 mode 101: left shift by k; vacated bits take the old data_out[0].
REQ-028 mode 110: rotate left by k.
REQ-029 mode 111: data_out <= data_in; shamt is ignored.
REQ-030 shamt=0 in any shift or rotate mode SHALL leave data_out unchanged for that step.
REQ-031 The edge that performs the final step SHALL return the FSM to IDLE and set done=1 for exactly the next cycle.
REQ-032 Latency SHALL be: accept at edge T; steps at edges T+1 through T+R; done high in the cycle following edge T+R.
REQ-033 While done=1 the FSM is in IDLE, so a new operation SHALL be acceptable in that same cycle (back-to-back, no bubble).
REQ-034 msb_out and lsb_out SHALL update on every non-reset edge, independent of FSM state.
REQ-035 Arithmetic SHALL be modulo within WIDTH bits; bits shifted past either end are discarded.

Reset
REQ-036 rst=1 at an edge SHALL force data_out=0, msb_out=0, lsb_out=0, done=0 and FSM=IDLE, overriding any accept or step on that edge.
REQ-037 rst asserted mid-RUN SHALL abort the operation with no done pulse; the block is op_ready=1 in the cycle after reset deasserts.

Verification (WIDTH=8)
REQ-038 Load: mode=111, repeat=1, data_in=0xA5 -> data_out=0xA5 one edge after accept, done pulse next cycle.
REQ-039 Rotate right: from 0xA5, mode=010, shamt=1, repeat=3 -> data_out sequence 0xD2, 0x69, 0xB4; done after the third step.
REQ-040 Arithmetic right: from 0x90, mode=011, shamt=2, repeat=2 -> 0xE4 then 0xF9.
REQ-041 Left shift with serial fill: from 0x01, mode=100, shamt=3, lsb_in=1, repeat=1 -> 0x0F; msb_out/lsb_out show the previous-cycle bits.
REQ-042 Boundaries: repeat=0 -> no data change, done next cycle. op_valid held high during RUN -> ignored, then a second op accepted in the done cycle.
REQ-043 Reset mid-RUN: rst at the 2nd step of a repeat=5 op -> all outputs 0, no done, op_ready=1 after release.
